// File: rtl/gpmc_target.sv
// GPMC non-multiplexed asynchronous target: synchronises the pad strobes and
// turns each bus cycle into a single-beat register-bus access, stalling reads via wait.
module gpmc_target #(
    parameter int                    ADDR_WIDTH       = 16,
    parameter int                    DATA_WIDTH       = 16,
    parameter int                    CS_COUNT         = 8,
    parameter int                    CS_INDEX         = 0,
    parameter bit                    WAIT_ACTIVE_HIGH = 1'b1,
    parameter int                    TIMEOUT          = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA     = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] gpmc_addr,
    input  logic [DATA_WIDTH-1:0] gpmc_data_i,
    output logic [DATA_WIDTH-1:0] gpmc_data_o,
    output logic                  gpmc_data_oe,
    input  logic [CS_COUNT-1:0]   gpmc_cs_n,
    input  logic                  gpmc_adv_n,
    input  logic                  gpmc_oe_n,
    input  logic                  gpmc_we_n,
    input  logic                  gpmc_be0_n,
    input  logic                  gpmc_be1_n,
    output logic                  gpmc_wait,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [1:0]            reg_be,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_valid,
    output logic                  proto_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int IW = ADDR_WIDTH + DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE, ACTIVE, WRITE, RD_REQ, RD_WAIT, RD_DRIVE, DONE
    } state_t;

    // Strobes {cs, adv, oe, we} and the address/data/byte-enable bundle share
    // the same two-stage depth so captured values line up with the strobes.
    logic [1:0][3:0]    strb_q, strb_d;
    logic [1:0][IW-1:0] in_q, in_d;

    logic                  cs_n_s, adv_n_s, oe_n_s, we_n_s, be1_n_s, be0_n_s, sel;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]            be_q, be_d;
    logic                  wr_en_q, wr_en_d;
    logic                  perr_q, perr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_o_q, data_o_d;
    logic                  stall;
    logic                  unused_cs;

    assign unused_cs = ^gpmc_cs_n;

    always_comb begin
        strb_d = {strb_q[0], {gpmc_cs_n[CS_INDEX], gpmc_adv_n, gpmc_oe_n, gpmc_we_n}};
        in_d   = {in_q[0], {gpmc_addr, gpmc_data_i, gpmc_be1_n, gpmc_be0_n}};
    end

    assign {cs_n_s, adv_n_s, oe_n_s, we_n_s}  = strb_q[1];
    assign {addr_s, data_s, be1_n_s, be0_n_s} = in_q[1];
    assign sel = ~cs_n_s;

    always_comb begin
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        be_d       = be_q;
        wr_en_d    = 1'b0;
        perr_d     = 1'b0;
        cnt_d      = cnt_q;
        data_o_d   = data_o_q;

        if (sel && !adv_n_s) reg_addr_d = addr_s;

        case (state_q)
            IDLE: if (sel) state_d = ACTIVE;
            ACTIVE: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (!we_n_s && oe_n_s) begin
                    state_d   = WRITE;
                    wr_data_d = data_s;
                    be_d      = ~{be1_n_s, be0_n_s};
                end else if (!oe_n_s && we_n_s) begin
                    state_d = RD_REQ;
                end else if (!oe_n_s && !we_n_s) begin
                    perr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                // The cycle that sees the strobe release must not latch:
                // data may already be changing on the pads.
                if (we_n_s || !sel) begin
                    wr_en_d = 1'b1;
                    state_d = DONE;
                end else begin
                    wr_data_d = data_s;
                    be_d      = ~{be1_n_s, be0_n_s};
                end
            end
            RD_REQ: begin
                cnt_d   = CW'(TIMEOUT);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (oe_n_s) begin
                    state_d = DONE;
                end else if (reg_rd_valid) begin
                    data_o_d = reg_rd_data;
                    state_d  = RD_DRIVE;
                end else if (cnt_q == '0) begin
                    data_o_d = TIMEOUT_DATA;
                    perr_d   = 1'b1;
                    state_d  = RD_DRIVE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RD_DRIVE: if (oe_n_s) state_d = DONE;
            DONE: if (!sel && oe_n_s && we_n_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q     <= '1;
            in_q       <= '0;
            state_q    <= IDLE;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            be_q       <= '0;
            wr_en_q    <= 1'b0;
            perr_q     <= 1'b0;
            cnt_q      <= '0;
            data_o_q   <= '0;
        end else begin
            strb_q     <= strb_d;
            in_q       <= in_d;
            state_q    <= state_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            be_q       <= be_d;
            wr_en_q    <= wr_en_d;
            perr_q     <= perr_d;
            cnt_q      <= cnt_d;
            data_o_q   <= data_o_d;
        end
    end

    // Stall starts as soon as the read strobe is seen and drops together with
    // the transition into RD_DRIVE, when gpmc_data_o gets its value.
    assign stall = (state_q == ACTIVE && sel && !oe_n_s && we_n_s) ||
                   (state_q == RD_REQ) || (state_q == RD_WAIT);

    assign gpmc_wait    = stall ^ ~WAIT_ACTIVE_HIGH;
    assign gpmc_data_oe = sel & ~oe_n_s & we_n_s;
    assign gpmc_data_o  = data_o_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wr_en    = wr_en_q;
    assign reg_wr_data  = wr_data_q;
    assign reg_be       = be_q;
    assign reg_rd_en    = (state_q == RD_REQ);
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_gpmc_target.sv
// Directed bench for gpmc_target: writes, reads, timeout, chip-select filtering,
// strobe conflict and reset during an outstanding read.
module tb_gpmc_target;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] gpmc_addr = '0, gpmc_data_i = '0, gpmc_data_o;
    logic        gpmc_data_oe;
    logic [7:0]  gpmc_cs_n = '1;
    logic        gpmc_adv_n = 1'b1, gpmc_oe_n = 1'b1, gpmc_we_n = 1'b1;
    logic        gpmc_be0_n = 1'b1, gpmc_be1_n = 1'b1;
    logic        gpmc_wait;
    logic [15:0] reg_addr, reg_wr_data;
    logic        reg_wr_en, reg_rd_en, proto_err;
    logic [1:0]  reg_be;
    logic [15:0] reg_rd_data = '0;
    logic        reg_rd_valid = 1'b0;

    gpmc_target dut (
        .clk(clk), .rst_n(rst_n),
        .gpmc_addr(gpmc_addr), .gpmc_data_i(gpmc_data_i), .gpmc_data_o(gpmc_data_o),
        .gpmc_data_oe(gpmc_data_oe), .gpmc_cs_n(gpmc_cs_n), .gpmc_adv_n(gpmc_adv_n),
        .gpmc_oe_n(gpmc_oe_n), .gpmc_we_n(gpmc_we_n), .gpmc_be0_n(gpmc_be0_n),
        .gpmc_be1_n(gpmc_be1_n), .gpmc_wait(gpmc_wait), .reg_addr(reg_addr),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_be(reg_be),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wr_cnt = 0, rd_cnt = 0, perr_cnt = 0, wait_cnt = 0;

    always @(negedge clk) begin
        if (reg_wr_en) wr_cnt++;
        if (reg_rd_en) rd_cnt++;
        if (proto_err) perr_cnt++;
        if (gpmc_wait) wait_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [15:0] a, input int csb);
        gpmc_cs_n[csb] = 1'b0;
        gpmc_adv_n     = 1'b0;
        gpmc_addr      = a;
        cyc(3);
        gpmc_adv_n = 1'b1;
        cyc(1);
    endtask

    task automatic release_bus();
        gpmc_oe_n = 1'b1; gpmc_we_n = 1'b1;
        gpmc_cs_n = '1;   gpmc_be0_n = 1'b1; gpmc_be1_n = 1'b1;
        gpmc_data_i = '0;
        cyc(4);
    endtask

    // ben_n is {be1_n, be0_n}; samples the strobe 2 and 3 edges after we_n rises.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] ben_n,
                            input int csb, output logic en2, output logic en3,
                            output logic [15:0] ga, output logic [15:0] gd, output logic [1:0] gbe);
        addr_phase(a, csb);
        gpmc_we_n = 1'b0;
        gpmc_data_i = d;
        {gpmc_be1_n, gpmc_be0_n} = ben_n;
        cyc(4);
        gpmc_we_n = 1'b1;
        cyc(2);
        en2 = reg_wr_en;
        cyc(1);
        en3 = reg_wr_en; ga = reg_addr; gd = reg_wr_data; gbe = reg_be;
        release_bus();
    endtask

    logic        e2, e3;
    logic [15:0] ga, gd;
    logic [1:0]  gbe;
    int          w0, r0, p0, wt0, n;

    initial begin
        // reset state
        cyc(2);
        check("rst_data_o", gpmc_data_o, 16'h0);
        check("rst_data_oe", gpmc_data_oe, 1'b0);
        check("rst_wait", gpmc_wait, 1'b0);
        check("rst_reg_addr", reg_addr, 16'h0);
        check("rst_wr_data_be", {reg_wr_data, reg_be}, 18'h0);
        check("rst_strobes", {reg_wr_en, reg_rd_en, proto_err}, 3'b000);
        rst_n = 1'b1;
        cyc(2);

        // full-word write
        w0 = wr_cnt; wt0 = wait_cnt;
        do_write(16'h0123, 16'hA55A, 2'b00, 0, e2, e3, ga, gd, gbe);
        check("wr_en_early", e2, 1'b0);
        check("wr_en_lat3", e3, 1'b1);
        check("wr_addr", ga, 16'h0123);
        check("wr_data", gd, 16'hA55A);
        check("wr_be11", gbe, 2'b11);
        check("wr_count", wr_cnt - w0, 1);
        check("wr_no_wait", wait_cnt - wt0, 0);

        // byte-lane writes
        do_write(16'h0200, 16'h1111, 2'b01, 0, e2, e3, ga, gd, gbe);
        check("wr_be10", {e3, gbe}, 3'b110);
        do_write(16'h0201, 16'h2222, 2'b10, 0, e2, e3, ga, gd, gbe);
        check("wr_be01", {e3, gbe}, 3'b101);
        check("wr_be01_data", gd, 16'h2222);

        // read with responder answering five cycles after reg_rd_en
        r0 = rd_cnt;
        addr_phase(16'h0040, 0);
        gpmc_oe_n = 1'b0;
        cyc(2);
        check("rd_en_early", reg_rd_en, 1'b0);
        cyc(1);
        check("rd_en_lat3", reg_rd_en, 1'b1);
        check("rd_addr", reg_addr, 16'h0040);
        check("rd_wait_on", gpmc_wait, 1'b1);
        check("rd_oe_on", gpmc_data_oe, 1'b1);
        cyc(4);
        reg_rd_valid = 1'b1; reg_rd_data = 16'h1234;
        check("rd_wait_held", gpmc_wait, 1'b1);
        cyc(1);
        reg_rd_valid = 1'b0; reg_rd_data = 16'h0;
        check("rd_data", gpmc_data_o, 16'h1234);
        check("rd_wait_off", gpmc_wait, 1'b0);
        cyc(3);
        check("rd_data_hold", gpmc_data_o, 16'h1234);
        gpmc_oe_n = 1'b1;
        cyc(2);
        check("rd_oe_off", gpmc_data_oe, 1'b0);
        release_bus();
        check("rd_count", rd_cnt - r0, 1);

        // read timeout
        p0 = perr_cnt;
        addr_phase(16'h0077, 0);
        gpmc_oe_n = 1'b0;
        cyc(3);
        check("to_rd_en", reg_rd_en, 1'b1);
        n = 0;
        while (gpmc_wait && n < 400) begin
            cyc(1);
            n++;
        end
        check("to_cycles", n, 257);
        check("to_data", gpmc_data_o, 16'hDEAD);
        check("to_perr_now", proto_err, 1'b1);
        cyc(3);
        check("to_perr_once", perr_cnt - p0, 1);
        release_bus();

        // other chip-select bit: nothing happens
        w0 = wr_cnt; r0 = rd_cnt; p0 = perr_cnt; wt0 = wait_cnt;
        do_write(16'h0333, 16'h7777, 2'b00, 1, e2, e3, ga, gd, gbe);
        check("cs1_no_wr", e3, 1'b0);
        addr_phase(16'h0044, 1);
        gpmc_oe_n = 1'b0;
        cyc(6);
        check("cs1_no_oe", gpmc_data_oe, 1'b0);
        release_bus();
        check("cs1_counts", {wr_cnt - w0, rd_cnt - r0, perr_cnt - p0, wait_cnt - wt0}, 0);

        // oe_n and we_n together
        w0 = wr_cnt; r0 = rd_cnt; p0 = perr_cnt;
        addr_phase(16'h0055, 0);
        gpmc_oe_n = 1'b0; gpmc_we_n = 1'b0;
        cyc(5);
        check("cfl_perr", perr_cnt - p0, 1);
        check("cfl_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);
        check("cfl_no_oe", gpmc_data_oe, 1'b0);
        release_bus();
        do_write(16'h0300, 16'hBEEF, 2'b00, 0, e2, e3, ga, gd, gbe);
        check("cfl_next_wr", {e3, gd}, {1'b1, 16'hBEEF});

        // reset while a read is outstanding
        addr_phase(16'h0010, 0);
        gpmc_oe_n = 1'b0;
        cyc(6);
        check("rr_wait_pre", gpmc_wait, 1'b1);
        r0 = rd_cnt;
        rst_n = 1'b0;
        #1;
        check("rr_wait_off", gpmc_wait, 1'b0);
        check("rr_oe_off", gpmc_data_oe, 1'b0);
        gpmc_oe_n = 1'b1; gpmc_cs_n = '1;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        reg_rd_valid = 1'b1; reg_rd_data = 16'h5555;
        cyc(1);
        reg_rd_valid = 1'b0;
        cyc(2);
        check("rr_late_valid", gpmc_data_o, 16'h0);
        check("rr_no_rd", rd_cnt - r0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
